// File: rtl/fetch_ctrl.sv
// Y86-64 fetch sequencer and pipeline-control unit. It owns the predicted-PC F register,
// selects the fetch PC, and generates stall/bubble controls through a run/drain/halt FSM.
module fetch_ctrl #(
  parameter int unsigned          PC_W     = 64,
  parameter logic [PC_W-1:0]      RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [PC_W-1:0] f_pred_pc_i,
  input  logic [3:0]      f_stat_i,
  input  logic [3:0]      d_icode_i,
  input  logic [3:0]      d_srcA_i,
  input  logic [3:0]      d_srcB_i,
  input  logic [3:0]      e_icode_i,
  input  logic [3:0]      e_dstM_i,
  input  logic            e_cnd_i,
  input  logic [3:0]      m_icode_i,
  input  logic            m_cnd_i,
  input  logic [PC_W-1:0] m_valA_i,
  input  logic [3:0]      m_stat_i,
  input  logic [3:0]      w_icode_i,
  input  logic [PC_W-1:0] w_valM_i,
  input  logic [3:0]      w_stat_i,
  output logic [PC_W-1:0] f_pc_o,
  output logic [PC_W-1:0] F_pred_pc_o,
  output logic            f_stall_o,
  output logic            d_stall_o,
  output logic            d_bubble_o,
  output logic            e_bubble_o,
  output logic            m_bubble_o,
  output logic            w_stall_o,
  output logic [1:0]      state_o,
  output logic [3:0]      halt_stat_o
);

  localparam logic [3:0] STAT_AOK  = 4'h1;
  localparam logic [3:0] I_JXX     = 4'h7;
  localparam logic [3:0] I_RET     = 4'h9;
  localparam logic [3:0] I_MRMOVQ  = 4'h5;
  localparam logic [3:0] I_POPQ    = 4'hB;
  localparam logic [3:0] REG_NONE  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] f_pred_q, f_pred_d;
  logic [3:0]      halt_stat_q, halt_stat_d;

  logic load_use, ret_pipe, mispredict, exc_m, exc_w, m_mispred, restart;

  // Hazard decode from the pipeline register contents
  always_comb begin
    load_use   = ((e_icode_i == I_MRMOVQ) || (e_icode_i == I_POPQ)) && (e_dstM_i != REG_NONE) &&
                 ((e_dstM_i == d_srcA_i) || (e_dstM_i == d_srcB_i));
    ret_pipe   = (d_icode_i == I_RET) || (e_icode_i == I_RET) || (m_icode_i == I_RET);
    mispredict = (e_icode_i == I_JXX) && !e_cnd_i;
    exc_m      = (m_stat_i != STAT_AOK);
    exc_w      = (w_stat_i != STAT_AOK);
    m_mispred  = (m_icode_i == I_JXX) && !m_cnd_i;
    // A drained halt on a wrong path resumes fetch, unless W is already exceptional
    restart    = (state_q == S_DRAIN) && m_mispred && !exc_w;
  end

  always_comb begin
    if (m_mispred)                f_pc_o = m_valA_i;
    else if (w_icode_i == I_RET)  f_pc_o = w_valM_i;
    else                          f_pc_o = f_pred_q;
  end

  // Next-state, register loads and control outputs
  always_comb begin
    state_d     = state_q;
    f_pred_d    = f_pred_q;
    halt_stat_d = halt_stat_q;
    f_stall_o   = 1'b1;
    d_stall_o   = 1'b0;
    d_bubble_o  = 1'b1;
    e_bubble_o  = 1'b1;
    m_bubble_o  = 1'b1;
    w_stall_o   = 1'b0;

    if (state_q == S_RUN || state_q == S_DRAIN) begin
      f_stall_o  = load_use | ret_pipe;
      d_stall_o  = load_use;
      d_bubble_o = mispredict | (ret_pipe & ~load_use);
      e_bubble_o = mispredict | load_use;
      m_bubble_o = exc_m | exc_w;
      w_stall_o  = exc_w;
      if (state_q == S_DRAIN && !restart) begin
        f_stall_o  = 1'b1;
        d_bubble_o = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: if (start_i) state_d = S_RUN;
      S_RUN: if ((f_stat_i != STAT_AOK) && !f_stall_o && !d_stall_o && !d_bubble_o)
        state_d = S_DRAIN;
      S_DRAIN: begin
        if (exc_w) begin
          state_d     = S_HALTED;
          halt_stat_d = w_stat_i;
        end else if (m_mispred) begin
          state_d = S_RUN;
        end
      end
      S_HALTED: if (start_i) begin
        state_d     = S_RUN;
        halt_stat_d = STAT_AOK;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_IDLE || state_q == S_HALTED) && start_i) f_pred_d = RESET_PC;
    else if (!f_stall_o)                                     f_pred_d = f_pred_i_sel();
  end

  function automatic logic [PC_W-1:0] f_pred_i_sel();
    return f_pred_pc_i;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      f_pred_q    <= RESET_PC;
      halt_stat_q <= STAT_AOK;
    end else begin
      state_q     <= state_d;
      f_pred_q    <= f_pred_d;
      halt_stat_q <= halt_stat_d;
    end
  end

  assign F_pred_pc_o = f_pred_q;
  assign state_o     = 2'(state_q);
  assign halt_stat_o = halt_stat_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a driver applies directed then random cycles and queues
// the reference model's expectations; a monitor pops and compares every cycle.
module tb_fetch_ctrl;

  localparam logic [63:0] RST_PC = 64'h100;

  typedef struct {
    logic rst, start;
    logic [63:0] f_pred_pc, m_valA, w_valM;
    logic [3:0] f_stat, d_icode, d_srcA, d_srcB, e_icode, e_dstM, m_icode, m_stat, w_icode, w_stat;
    logic e_cnd, m_cnd;
  } stim_t;

  typedef struct {
    logic [63:0] f_pc, fpred;
    logic [5:0]  ctl;   // {f_stall,d_stall,d_bubble,e_bubble,m_bubble,w_stall}
    logic [1:0]  state;
    logic [3:0]  halt;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [63:0] f_pred_pc = '0, m_valA = '0, w_valM = '0;
  logic [3:0] f_stat = 4'h1, d_icode = 4'h1, d_srcA = 4'hF, d_srcB = 4'hF, e_icode = 4'h1,
              e_dstM = 4'hF, m_icode = 4'h1, m_stat = 4'h1, w_icode = 4'h1, w_stat = 4'h1;
  logic e_cnd = 1'b1, m_cnd = 1'b1;
  logic [63:0] f_pc, F_pred_pc;
  logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall;
  logic [1:0] state;
  logic [3:0] halt_stat;

  int checks = 0, failures = 0;
  exp_t sb[$];

  // Reference state: mode 0 idle, 1 running, 2 draining, 3 halted
  logic [1:0]  m_mode = 2'd0;
  logic [63:0] m_f = RST_PC;
  logic [3:0]  m_halt = 4'h1;

  always #5 clk = ~clk;

  fetch_ctrl #(.PC_W(64), .RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .f_pred_pc_i(f_pred_pc), .f_stat_i(f_stat),
    .d_icode_i(d_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB), .e_icode_i(e_icode),
    .e_dstM_i(e_dstM), .e_cnd_i(e_cnd), .m_icode_i(m_icode), .m_cnd_i(m_cnd), .m_valA_i(m_valA),
    .m_stat_i(m_stat), .w_icode_i(w_icode), .w_valM_i(w_valM), .w_stat_i(w_stat),
    .f_pc_o(f_pc), .F_pred_pc_o(F_pred_pc), .f_stall_o(f_stall), .d_stall_o(d_stall),
    .d_bubble_o(d_bubble), .e_bubble_o(e_bubble), .m_bubble_o(m_bubble), .w_stall_o(w_stall),
    .state_o(state), .halt_stat_o(halt_stat)
  );

  function automatic stim_t quiet();
    stim_t s;
    s.rst = 0; s.start = 0; s.f_pred_pc = 64'h0; s.m_valA = 64'h0; s.w_valM = 64'h0;
    s.f_stat = 1; s.d_icode = 1; s.d_srcA = 15; s.d_srcB = 15; s.e_icode = 1; s.e_dstM = 15;
    s.m_icode = 1; s.m_stat = 1; s.w_icode = 1; s.w_stat = 1; s.e_cnd = 1; s.m_cnd = 1;
    return s;
  endfunction

  function automatic logic [3:0] r_icode();
    return ($urandom_range(0, 1) == 0) ? 4'h1 : 4'($urandom_range(0, 11));
  endfunction

  function automatic logic [3:0] r_reg();
    return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
  endfunction

  function automatic logic [3:0] r_stat(input int unsigned pct_bad);
    return ($urandom_range(0, 99) < pct_bad) ? 4'($urandom_range(2, 4)) : 4'h1;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst = ($urandom_range(0, 199) == 0); s.start = ($urandom_range(0, 2) == 0);
    s.f_pred_pc = {32'h0, $urandom}; s.m_valA = {$urandom, $urandom}; s.w_valM = {32'h0, $urandom};
    s.f_stat = r_stat(12); s.m_stat = r_stat(8); s.w_stat = r_stat(15);
    s.d_icode = r_icode(); s.e_icode = r_icode(); s.m_icode = r_icode(); s.w_icode = r_icode();
    s.d_srcA = r_reg(); s.d_srcB = r_reg(); s.e_dstM = r_reg();
    s.e_cnd = 1'($urandom_range(0, 1)); s.m_cnd = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // Expected outputs this cycle plus the register values after the next edge
  task automatic model(input stim_t s, output exp_t e, output logic [1:0] nmode,
                       output logic [63:0] nf, output logic [3:0] nh);
    bit lu, rp, mp, ew, fix, stopped, resume;
    bit fs, ds, db, eb, mb, ws;
    lu = (s.e_icode == 5 || s.e_icode == 11) && s.e_dstM != 15 &&
         (s.e_dstM == s.d_srcA || s.e_dstM == s.d_srcB);
    rp = (s.d_icode == 9) || (s.e_icode == 9) || (s.m_icode == 9);
    mp = (s.e_icode == 7) && !s.e_cnd;
    ew = (s.w_stat != 1);
    fix = (s.m_icode == 7) && !s.m_cnd;
    stopped = (m_mode == 0) || (m_mode == 3);
    resume = (m_mode == 2) && fix && !ew;
    if (stopped) begin
      fs = 1; ds = 0; db = 1; eb = 1; mb = 1; ws = 0;
    end else begin
      fs = lu | rp; ds = lu; db = mp | (rp & !lu); eb = mp | lu;
      mb = (s.m_stat != 1) | ew; ws = ew;
      if (m_mode == 2 && !resume) begin fs = 1; db = 1; end
    end
    e.f_pc = fix ? s.m_valA : (s.w_icode == 9) ? s.w_valM : m_f;
    e.ctl = {fs, ds, db, eb, mb, ws};
    e.state = m_mode; e.fpred = m_f; e.halt = m_halt;
    nmode = m_mode; nf = m_f; nh = m_halt;
    case (m_mode)
      2'd0: if (s.start) nmode = 1;
      2'd1: if (s.f_stat != 1 && !fs && !ds && !db) nmode = 2;
      2'd2: if (ew) begin nmode = 3; nh = s.w_stat; end else if (fix) nmode = 1;
      default: if (s.start) begin nmode = 1; nh = 1; end
    endcase
    if (stopped && s.start) nf = RST_PC;
    else if (!fs) nf = s.f_pred_pc;
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    logic [1:0] nmode;
    logic [63:0] nf;
    logic [3:0] nh;
    @(negedge clk);
    rst = s.rst; start = s.start; f_pred_pc = s.f_pred_pc; f_stat = s.f_stat;
    d_icode = s.d_icode; d_srcA = s.d_srcA; d_srcB = s.d_srcB; e_icode = s.e_icode;
    e_dstM = s.e_dstM; e_cnd = s.e_cnd; m_icode = s.m_icode; m_cnd = s.m_cnd; m_valA = s.m_valA;
    m_stat = s.m_stat; w_icode = s.w_icode; w_valM = s.w_valM; w_stat = s.w_stat;
    #1;
    if (s.rst) begin m_mode = 0; m_f = RST_PC; m_halt = 1; end
    model(s, e, nmode, nf, nh);
    sb.push_back(e);
    @(posedge clk);
    if (!s.rst) begin m_mode = nmode; m_f = nf; m_halt = nh; end
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the oldest queued expectation
  initial forever begin
    @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("f_pc", f_pc, e.f_pc);
      cmp("ctl", 64'({f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall}), 64'(e.ctl));
      cmp("state", 64'(state), 64'(e.state));
      cmp("F_pred_pc", F_pred_pc, e.fpred);
      cmp("halt_stat", 64'(halt_stat), 64'(e.halt));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    s = quiet(); s.rst = 1;
    apply(s); apply(s);
    s.rst = 0; apply(s);
    s.start = 1; s.f_pred_pc = 64'h0A; apply(s);
    s.start = 0; apply(s); apply(s);
    s = quiet(); s.e_icode = 5; s.e_dstM = 3; s.d_srcA = 3; s.f_pred_pc = 64'h55; apply(s);
    s = quiet(); s.e_icode = 7; s.e_cnd = 0; apply(s);
    s = quiet(); s.m_icode = 7; s.m_cnd = 0; s.m_valA = 64'h40; s.f_pred_pc = 64'h40; apply(s);
    s = quiet(); s.d_icode = 9; apply(s);
    s = quiet(); s.e_icode = 9; apply(s);
    s = quiet(); s.m_icode = 9; apply(s);
    s = quiet(); s.w_icode = 9; s.w_valM = 64'h123; s.f_pred_pc = 64'h123; apply(s);
    s = quiet(); s.f_stat = 2; s.f_pred_pc = 64'h200; apply(s);
    s = quiet(); apply(s); apply(s);
    s.w_stat = 2; apply(s);
    s = quiet(); apply(s);
    s.start = 1; apply(s);
    s.start = 0; s.f_pred_pc = 64'h300; apply(s);
    s.f_stat = 2; apply(s);
    s = quiet(); s.m_icode = 7; s.m_cnd = 0; s.m_valA = 64'h80; s.f_pred_pc = 64'h80; apply(s);
    s = quiet(); s.f_pred_pc = 64'h88; apply(s);
    s.rst = 1; apply(s);
    s.rst = 0; apply(s);
    for (int i = 0; i < 3000; i++) apply(rand_stim());
    s = quiet(); apply(s);
    @(negedge clk); #4;
    cmp("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
